// File: rtl/noobs_wb_pkg.sv
// Shared constants and types for the register-file write-back path.
package noobs_wb_pkg;
  localparam int REG_SEL_W  = 2;
  localparam int REG_DATA_W = 8;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DBG = 2;

  localparam logic WB_ARB    = 1'b0;
  localparam logic WB_LOCKED = 1'b1;

  typedef struct packed {
    logic [REG_SEL_W-1:0]  sel;
    logic [REG_DATA_W-1:0] data;
  } wb_beat_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int num_req);
    if (int'(idx) >= num_req - 1) return 2'd0;
    return idx + 2'd1;
  endfunction
endpackage

// File: rtl/reg_wb_rr_pick.sv
// Rotating priority encoder: first valid requester at or above rr_ptr, wrapping.
module reg_wb_rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               grant_any
);
  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = 2'(cand);
        grant_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin
// with bounded burst locking, registered wr_* output stage.
module reg_wb_arbiter
  import noobs_wb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [2*NUM_REQ-1:0]  req_sel,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wr_en,
  output logic [1:0]            wr_sel,
  output logic [7:0]            wr_data,
  output logic [1:0]            grant_id,
  output logic                  locked
);
  wb_beat_t beat_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign beat_arr[gi] = {req_sel[REG_SEL_W*gi +: REG_SEL_W],
                             req_data[REG_DATA_W*gi +: REG_DATA_W]};
    end
  endgenerate

  logic       state_q, state_d;
  logic [1:0] lock_id_q, lock_id_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       wr_en_q, wr_en_d;
  wb_beat_t   beat_q, beat_d;
  logic [1:0] grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [1:0]         pick_idx;
  logic               pick_any;

  reg_wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  logic               owner_valid;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [1:0]         gnt_idx;
  logic               accept;
  logic [3:0]         burst_inc;

  assign owner_valid = (state_q == WB_LOCKED) && req_valid[lock_id_q];
  assign burst_inc   = burst_cnt_q + 4'd1;

  // An idle owner falls straight through to round-robin in the same cycle.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    accept     = 1'b0;
    if (reset_ && !flush) begin
      if (owner_valid) begin
        gnt_onehot[lock_id_q] = 1'b1;
        gnt_idx               = lock_id_q;
        accept                = 1'b1;
      end else if (pick_any) begin
        gnt_onehot = pick_grant;
        gnt_idx    = pick_idx;
        accept     = 1'b1;
      end
    end
  end

  assign req_ready = gnt_onehot;

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      state_d     = WB_ARB;
      burst_cnt_d = '0;
    end else if (accept) begin
      rr_ptr_d = rr_next(gnt_idx, NUM_REQ);
      if (owner_valid) begin
        if (!req_lock[gnt_idx] || int'(burst_inc) >= MAX_BURST) begin
          state_d     = WB_ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_inc;
        end
      end else if (req_lock[gnt_idx] && MAX_BURST > 1) begin
        state_d     = WB_LOCKED;
        lock_id_d   = gnt_idx;
        burst_cnt_d = 4'd1;
      end else begin
        state_d     = WB_ARB;
        burst_cnt_d = '0;
      end
    end else begin
      state_d     = WB_ARB;
      burst_cnt_d = '0;
    end
  end

  // sel/data hold when idle; only wr_en qualifies the port.
  always_comb begin
    wr_en_d    = accept;
    beat_d     = accept ? beat_arr[gnt_idx] : beat_q;
    grant_id_d = accept ? gnt_idx : 2'd0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= WB_ARB;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      beat_q      <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      beat_q      <= beat_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_sel   = beat_q.sel;
  assign wr_data  = beat_q.data;
  assign grant_id = grant_id_q;
  assign locked   = (state_q == WB_LOCKED);
endmodule
